// File: rtl/sobel_stream.sv
// sobel_stream: streaming 3x3 Sobel edge filter between an input and an output pixel FIFO.
// One output pixel is produced per input pixel. Border pixels are forced to BORDER_VAL.
// An optional binary threshold mode is available, and frames run back to back.
module sobel_stream #(
  parameter int unsigned IMG_WIDTH  = 720,
  parameter int unsigned IMG_HEIGHT = 540,
  parameter int unsigned DWIDTH     = 8,
  parameter int unsigned BORDER_VAL = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              in_rd_en,
  input  logic [DWIDTH-1:0] in_dout,
  input  logic              in_empty,
  output logic              out_wr_en,
  output logic [DWIDTH-1:0] out_din,
  input  logic              out_full,
  input  logic              threshold_en,
  input  logic [DWIDTH-1:0] threshold,
  output logic              frame_done
);

  localparam int unsigned LAG  = IMG_WIDTH + 1;
  localparam int unsigned HIST = 2 * IMG_WIDTH + 2;
  localparam int unsigned GW   = DWIDTH + 3;
  localparam int unsigned CW   = $clog2(LAG) + 1;
  localparam int unsigned XW   = $clog2(IMG_WIDTH) + 1;
  localparam int unsigned YW   = $clog2(IMG_HEIGHT) + 1;

  localparam logic [CW-1:0]     CNT_LAST   = CW'(LAG - 1);
  localparam logic [XW-1:0]     X_LAST     = XW'(IMG_WIDTH - 1);
  localparam logic [XW-1:0]     X_PEN      = XW'(IMG_WIDTH - 2);
  localparam logic [YW-1:0]     Y_LAST     = YW'(IMG_HEIGHT - 1);
  localparam logic [YW-1:0]     Y_PEN      = YW'(IMG_HEIGHT - 2);
  localparam logic [DWIDTH-1:0] MAX_PIX    = {DWIDTH{1'b1}};
  localparam logic [DWIDTH-1:0] BORDER_PIX = DWIDTH'(BORDER_VAL);

  localparam logic [1:0] S_FILL  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     fill_cnt_q, fill_cnt_d;
  logic [CW-1:0]     drain_cnt_q, drain_cnt_d;
  logic [XW-1:0]     out_x_q, out_x_d;
  logic [YW-1:0]     out_y_q, out_y_d;
  logic              thr_en_q, thr_en_d;
  logic [DWIDTH-1:0] thr_q, thr_d;

  logic              pop_c;
  logic              push_c;
  logic              done_c;
  logic              border_c;
  logic [DWIDTH-1:0] interior_c;

  logic [DWIDTH-1:0] hist_q [HIST];

  logic signed [GW-1:0] gx_c, gy_c;
  logic [GW-1:0]        ax_c, ay_c, half_c;
  logic [DWIDTH-1:0]    mag_c;

  function automatic logic signed [GW-1:0] ext(input logic [DWIDTH-1:0] p);
    return $signed({3'b000, p});
  endfunction

  // Pixel history: hist_q[i] holds input index k-1-i; it shifts on every pop
  always_ff @(posedge clk) begin
    if (in_rd_en) begin
      hist_q[0] <= in_dout;
      for (int i = 1; i < int'(HIST); i++) begin
        hist_q[i] <= hist_q[i-1];
      end
    end
  end

  // Sobel kernel on the window centred at output j = k-LAG; bottom-right pixel is the live FIFO head
  always_comb begin
    gx_c = (ext(hist_q[2*IMG_WIDTH-1]) + (ext(hist_q[IMG_WIDTH-1]) <<< 1) + ext(in_dout))
         - (ext(hist_q[2*IMG_WIDTH+1]) + (ext(hist_q[IMG_WIDTH+1]) <<< 1) + ext(hist_q[1]));
    gy_c = (ext(hist_q[1]) + (ext(hist_q[0]) <<< 1) + ext(in_dout))
         - (ext(hist_q[2*IMG_WIDTH+1]) + (ext(hist_q[2*IMG_WIDTH]) <<< 1) + ext(hist_q[2*IMG_WIDTH-1]));
    ax_c   = gx_c[GW-1] ? $unsigned(-gx_c) : $unsigned(gx_c);
    ay_c   = gy_c[GW-1] ? $unsigned(-gy_c) : $unsigned(gy_c);
    half_c = (ax_c + ay_c) >> 1;
    mag_c  = (|half_c[GW-1:DWIDTH]) ? MAX_PIX : half_c[DWIDTH-1:0];
    if (thr_en_q) begin
      interior_c = (mag_c >= thr_q) ? MAX_PIX : '0;
    end else begin
      interior_c = mag_c;
    end
  end

  assign border_c = (out_x_q == '0) || (out_x_q == X_LAST) ||
                    (out_y_q == '0) || (out_y_q == Y_LAST);

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FILL;
      fill_cnt_q  <= '0;
      drain_cnt_q <= '0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      thr_en_q    <= 1'b0;
      thr_q       <= '0;
    end else begin
      state_q     <= state_d;
      fill_cnt_q  <= fill_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      out_x_q     <= out_x_d;
      out_y_q     <= out_y_d;
      thr_en_q    <= thr_en_d;
      thr_q       <= thr_d;
    end
  end

  // Next-state, counters and FIFO handshakes
  always_comb begin
    state_d     = state_q;
    fill_cnt_d  = fill_cnt_q;
    drain_cnt_d = drain_cnt_q;
    out_x_d     = out_x_q;
    out_y_d     = out_y_q;
    thr_en_d    = thr_en_q;
    thr_d       = thr_q;
    pop_c       = 1'b0;
    push_c      = 1'b0;
    done_c      = 1'b0;

    // A write always advances the output raster position, wrapping at end of frame
    case (state_q)
      S_FILL: begin
        if (!in_empty) begin
          pop_c = 1'b1;
          if (fill_cnt_q == '0) begin
            thr_en_d = threshold_en;
            thr_d    = threshold;
          end
          if (fill_cnt_q == CNT_LAST) begin
            fill_cnt_d = '0;
            state_d    = S_RUN;
          end else begin
            fill_cnt_d = fill_cnt_q + 1'b1;
          end
        end
      end
      S_RUN: begin
        if (!in_empty && !out_full) begin
          pop_c  = 1'b1;
          push_c = 1'b1;
          // Output N-LAG-1 pairs with the pop of the last input pixel
          if (out_x_q == X_PEN && out_y_q == Y_PEN) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (!out_full) begin
          push_c = 1'b1;
          if (drain_cnt_q == CNT_LAST) begin
            drain_cnt_d = '0;
            done_c      = 1'b1;
            state_d     = S_FILL;
          end else begin
            drain_cnt_d = drain_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_FILL;
    endcase

    if (push_c) begin
      if (out_x_q == X_LAST) begin
        out_x_d = '0;
        out_y_d = (out_y_q == Y_LAST) ? '0 : out_y_q + 1'b1;
      end else begin
        out_x_d = out_x_q + 1'b1;
      end
    end
  end

  // Output pixel: kernel result for interior, constant for border and drain
  always_comb begin
    out_din = '0;
    if (state_q == S_RUN) begin
      out_din = border_c ? BORDER_PIX : interior_c;
    end else if (state_q == S_DRAIN) begin
      out_din = BORDER_PIX;
    end
  end

  // Reset masks the pop strobe immediately, even while FILL sees a non-empty FIFO
  assign in_rd_en   = pop_c & rst_n;
  assign out_wr_en  = push_c;
  assign frame_done = done_c;

endmodule

// File: tb/tb_sobel_stream.sv
// tb_sobel_stream: directed frames on a 5x4 image with hand-computed expected outputs.
module tb_sobel_stream;

  localparam int unsigned W  = 5;
  localparam int unsigned H  = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned BV = 0;
  localparam int N   = 20;
  localparam int LAG = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_rd_en;
  logic [DW-1:0] in_dout = '0;
  logic          in_empty = 1'b1;
  logic          out_wr_en;
  logic [DW-1:0] out_din;
  logic          out_full = 1'b0;
  logic          threshold_en = 1'b0;
  logic [DW-1:0] threshold = '0;
  logic          frame_done;

  int n_vec  = 0;
  int n_miss = 0;

  logic [DW-1:0] in_q [$];
  logic [DW-1:0] out_q [$];
  int            done_at [$];
  int            done_cyc [$];
  int            pops;
  int            k_mod = 0;
  int            viol_empty, viol_full, viol_runpop;

  sobel_stream #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .DWIDTH    (DW),
    .BORDER_VAL(BV)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_rd_en    (in_rd_en),
    .in_dout     (in_dout),
    .in_empty    (in_empty),
    .out_wr_en   (out_wr_en),
    .out_din     (out_din),
    .out_full    (out_full),
    .threshold_en(threshold_en),
    .threshold   (threshold),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // kind 0: flat 100, 1: vertical edge (cols 3-4 = 200), 2: ramp 10*col
  task automatic push_frame(input int kind);
    for (int y = 0; y < int'(H); y++) begin
      for (int x = 0; x < int'(W); x++) begin
        case (kind)
          0:       in_q.push_back(8'd100);
          1:       in_q.push_back((x >= 3) ? 8'd200 : 8'd0);
          default: in_q.push_back(8'(10 * x));
        endcase
      end
    end
  endtask

  // Observe one cycle's handshakes (sampled mid-cycle) and model both FIFOs
  task automatic sample_cycle(input int cyc, input int chg_pops, input logic [DW-1:0] chg_val);
    if (in_rd_en && in_empty) viol_empty++;
    if (out_wr_en && out_full) viol_full++;
    if (in_rd_en && out_full && k_mod >= LAG) viol_runpop++;
    if (out_wr_en) out_q.push_back(out_din);
    if (frame_done) begin
      done_at.push_back(out_q.size());
      done_cyc.push_back(cyc);
    end
    if (in_rd_en) begin
      if (in_q.size() != 0) void'(in_q.pop_front());
      pops++;
      k_mod = (k_mod + 1) % N;
      if (pops == chg_pops) threshold = chg_val;
    end
  endtask

  // Stream the queued pixels; stop after stop_pops pops (if >0) or once want writes were seen
  task automatic run_stream(input bit bp, input int stop_pops, input int want,
                            input int chg_pops, input logic [DW-1:0] chg_val);
    int cyc;
    bit gap;
    cyc = 0;
    pops = 0;
    out_q.delete();
    done_at.delete();
    done_cyc.delete();
    viol_empty = 0;
    viol_full = 0;
    viol_runpop = 0;
    while (cyc < 3000) begin
      if (stop_pops > 0 ? pops >= stop_pops : out_q.size() >= want) break;
      @(negedge clk);
      gap      = bp && ($urandom_range(0, 3) == 0);
      in_empty = (in_q.size() == 0) || gap;
      in_dout  = (in_q.size() != 0) ? in_q[0] : 8'h00;
      out_full = bp && ($urandom_range(0, 2) == 0);
      #1;
      sample_cycle(cyc, chg_pops, chg_val);
      cyc++;
    end
    check_eq("no_timeout", 32'(cyc < 3000), 1);
    if (stop_pops == 0) begin
      repeat (6) begin
        @(negedge clk);
        in_empty = 1'b1;
        out_full = 1'b0;
        #1;
        sample_cycle(cyc, 0, 8'h00);
        cyc++;
      end
    end
  endtask

  // Compare one 5x4 output frame; v1..v3 are the interior values for columns 1..3
  task automatic check_frame(input string tag, input int base, input int v1, input int v2, input int v3);
    int x, y, exp;
    logic [31:0] got;
    for (int i = 0; i < N; i++) begin
      x = i % int'(W);
      y = i / int'(W);
      if (x == 0 || x == int'(W) - 1 || y == 0 || y == int'(H) - 1) exp = int'(BV);
      else exp = (x == 1) ? v1 : (x == 2) ? v2 : v3;
      got = (base + i < out_q.size()) ? 32'(out_q[base + i]) : 32'hFFFF_FFFF;
      check_eq($sformatf("%s[%0d]", tag, base + i), got, 32'(exp));
    end
  endtask

  task automatic check_handshake(input string tag);
    check_eq({tag, "_pop_empty"}, 32'(viol_empty), 0);
    check_eq({tag, "_wr_full"}, 32'(viol_full), 0);
    check_eq({tag, "_pop_full_run"}, 32'(viol_runpop), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    check_eq("rst_in_rd_en", 32'(in_rd_en), 0);
    check_eq("rst_out_wr_en", 32'(out_wr_en), 0);
    check_eq("rst_out_din", 32'(out_din), 0);
    check_eq("rst_frame_done", 32'(frame_done), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Flat frame: everything zero, one frame_done on the 20th write after N+LAG cycles
    push_frame(0);
    run_stream(1'b0, 0, N, 0, 8'h00);
    check_eq("flat_writes", 32'(out_q.size()), N);
    check_frame("flat", 0, 0, 0, 0);
    check_eq("flat_ndone", 32'(done_at.size()), 1);
    if (done_at.size() >= 1) begin
      check_eq("flat_done_at", 32'(done_at[0]), N);
      check_eq("flat_done_cyc", 32'(done_cyc[0]), N + LAG - 1);
    end

    // Vertical edge, stall-free
    push_frame(1);
    run_stream(1'b0, 0, N, 0, 8'h00);
    check_eq("edge_writes", 32'(out_q.size()), N);
    check_frame("edge", 0, 0, 255, 255);
    check_eq("edge_ndone", 32'(done_at.size()), 1);

    // Ramp, raw magnitude 40
    threshold_en = 1'b0;
    push_frame(2);
    run_stream(1'b0, 0, N, 0, 8'h00);
    check_frame("ramp_mag", 0, 40, 40, 40);

    // Ramp, threshold 40 (latched; a later change to 255 must not matter)
    threshold_en = 1'b1;
    threshold    = 8'd40;
    push_frame(2);
    run_stream(1'b0, 0, N, 3, 8'd255);
    check_frame("ramp_thr40", 0, 255, 255, 255);

    // Ramp, threshold 41 (latched; a later change to 0 must not matter)
    threshold = 8'd41;
    push_frame(2);
    run_stream(1'b0, 0, N, 3, 8'd0);
    check_frame("ramp_thr41", 0, 0, 0, 0);
    threshold_en = 1'b0;
    threshold    = 8'd0;

    // Edge frame with random FIFO stalls on both sides
    push_frame(1);
    run_stream(1'b1, 0, N, 0, 8'h00);
    check_eq("bp_writes", 32'(out_q.size()), N);
    check_frame("bp_edge", 0, 0, 255, 255);
    check_eq("bp_ndone", 32'(done_at.size()), 1);
    check_handshake("bp");

    // Two edge frames back to back
    push_frame(1);
    push_frame(1);
    run_stream(1'b0, 0, 2 * N, 0, 8'h00);
    check_eq("b2b_writes", 32'(out_q.size()), 2 * N);
    check_frame("b2b_f0", 0, 0, 255, 255);
    check_frame("b2b_f1", N, 0, 255, 255);
    check_eq("b2b_ndone", 32'(done_at.size()), 2);
    if (done_at.size() >= 2) begin
      check_eq("b2b_done_at1", 32'(done_at[1]), 2 * N);
      check_eq("b2b_done_cyc0", 32'(done_cyc[0]), N + LAG - 1);
      check_eq("b2b_done_cyc1", 32'(done_cyc[1]), 2 * (N + LAG) - 1);
    end
    check_handshake("b2b");

    // Reset after 7 pops of a frame: outputs drop immediately
    push_frame(0);
    run_stream(1'b0, 7, 0, 0, 8'h00);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_in_rd_en", 32'(in_rd_en), 0);
    check_eq("mid_rst_out_wr_en", 32'(out_wr_en), 0);
    check_eq("mid_rst_out_din", 32'(out_din), 0);
    check_eq("mid_rst_frame_done", 32'(frame_done), 0);
    in_empty = 1'b1;
    in_q.delete();
    k_mod = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    push_frame(0);
    run_stream(1'b0, 0, N, 0, 8'h00);
    check_eq("post_rst_writes", 32'(out_q.size()), N);
    check_frame("post_rst_flat", 0, 0, 0, 0);
    check_eq("post_rst_ndone", 32'(done_at.size()), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/sobel_stream.md
# sobel_stream

Parametrised streaming Sobel edge filter sitting between an input pixel FIFO and an output pixel FIFO in the image pipeline. It is the successor to the fixed 8-bit Sobel stage. It adds:
- configurable pixel width and image size;
- a full-frame output (one output pixel per input pixel, border pixels forced to a constant);
- an optional binary threshold mode;
- continuous back-to-back frame processing without reset.

## Interface
- IMG_WIDTH, 720, pixels per row; minimum 3.
- IMG_HEIGHT, 540, rows per frame; minimum 3.
- DWIDTH, 8, bits per pixel for input and output.
- BORDER_VAL, 0, value emitted for every border pixel (row 0, row IMG_HEIGHT-1, column 0, column IMG_WIDTH-1).
- clock  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_rd_en  out  1  pops in_dout from the input FIFO this cycle.
- in_dout  in  DWIDTH  input FIFO head. It is first-word-fall-through and valid whenever in_empty=0.
- in_empty  in  1  input FIFO empty.
- out_wr_en  out  1  pushes out_din into the output FIFO this cycle.
- out_din  out  DWIDTH  output pixel.
- out_full  in  1  output FIFO full.
- threshold_en  in  1  selects binary threshold mode.
- threshold  in  DWIDTH  threshold value used in threshold mode.
- frame_done  out  1  one-cycle pulse in the cycle the last pixel of a frame is written.

## Operation
- Pixels arrive in raster order. Define N = IMG_WIDTH*IMG_HEIGHT and L = IMG_WIDTH+1.
- Storage is a 2*IMG_WIDTH+2 entry pixel history holding input indices k-1 … k-2*IMG_WIDTH-2. It shifts by one on every pop.
- The 3x3 window for output index j = k-L takes its bottom-right pixel from the live in_dout (index k) and its other 8 pixels from the history.
- History is never cleared between frames. Stale data only feeds border outputs.
- Kernel, with p0..p8 the window in row-major order from top-left:
  - Gx = (p2+2p5+p8)-(p0+2p3+p6)
  - Gy = (p6+2p7+p8)-(p0+2p1+p2)
  - Both are signed, DWIDTH+3 bits.
- Magnitude: mag = (|Gx|+|Gy|)>>1, saturated to 2^DWIDTH-1.
- Interior output: mag when threshold_en=0. When threshold_en=1 it is (mag>=threshold ? 2^DWIDTH-1 : 0).
- threshold_en and threshold are latched on the first pop of each frame and held for the whole frame.
- Border output: BORDER_VAL in both modes.
- FSM has three states:
  - FILL: pops up to L pixels and writes nothing. The pop condition is in_empty=0 only. After the L-th pop, go to RUN.
  - RUN: transfers when in_empty=0 and out_full=0. A transfer pops index k and writes output index k-L in the same cycle; if either condition is false, neither happens. After the pop of index N-1, go to DRAIN.
  - DRAIN: writes BORDER_VAL whenever out_full=0, L times. These are output indices N-L … N-1, all of which are border pixels. On the L-th write, assert frame_done and go to FILL.
- Counters:
  - fill count in 0..L-1;
  - output column/row (out_x, out_y), which wrap at IMG_WIDTH and at the end of the frame;
  - drain count in 0..L-1.
  - All counter widths are $clog2 of their range plus 1.
- Reset mid-frame: FSM goes to FILL, all counters are zeroed, and the partial frame is discarded. The next popped pixel is index 0 of a new frame.

## Timing
- Reset values: in_rd_en=0, out_wr_en=0, out_din=0, frame_done=0, state=FILL, all counters 0.
- in_rd_en, out_wr_en, out_din and frame_done are combinational from registered state, the FIFO flags and in_dout. There is no registered output stage.
- Latency: output j is written in the same cycle that input j+L is popped.
- Throughput is 1 pixel/cycle in RUN.
- Minimum frame time is N+L cycles (L fill + N-L run + L drain). The next frame's FILL may begin the cycle after frame_done.
- Never pop while in_empty=1. Never write while out_full=1.
- In RUN, out_full=1 stalls input consumption even when in_empty=0.

## Test plan
- Flat frame, W=5, H=4, all pixels 100, threshold_en=0 -> exactly 20 writes, all 0; one frame_done on the 20th write.
- Vertical edge, W=5, H=4:
  - Stimulus: columns 0-2 = 0, columns 3-4 = 200.
  - Rows 1 and 2 -> 0,0,255,255,0 (Gx=800, saturated). Rows 0 and 3 -> all 0.
- Ramp, W=5, H=4, pixel=10*col, threshold_en=1 -> interior mag is 40.
  - threshold=40 -> interior 255; threshold=41 -> interior 0. Border stays BORDER_VAL.
- Backpressure: same stimulus as the edge test, with random in_empty gaps and random out_full assertion.
  - Output stream must be identical to the stall-free run.
  - No pop while out_full=1 in RUN; no write while out_full=1; no pop while in_empty=1.
- Back-to-back frames: two edge frames with no idle cycles -> 40 writes, frame_done pulses exactly twice, and the second frame's outputs are identical to the first.
- Reset asserted after 7 pops of a frame -> all outputs 0 immediately (asynchronous). After release, a complete flat frame yields 20 zero writes and one frame_done.
